snake_cmd_decoder: RTL and testbench



---
 rtl/snake_pkg.sv | 55 +++++
 rtl/snake_turn_fifo.sv | 58 +++++
 rtl/snake_cmd_decoder.sv | 137 +++++++++++++
 tb/tb_snake_cmd_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared directions, byte codes and decode helpers for the snake command decoder
// Contents: DIR_* heading codes, ASCII_* byte constants, parser state type,
//           is_reverse(), decode_arrow(), decode_wasd().
package snake_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [7:0] ASCII_ESC      = 8'h1B;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] ASCII_A        = 8'h41;
   localparam logic [7:0] ASCII_B        = 8'h42;
   localparam logic [7:0] ASCII_C        = 8'h43;
   localparam logic [7:0] ASCII_D        = 8'h44;
   localparam logic [7:0] ASCII_W_LC     = 8'h77;
   localparam logic [7:0] ASCII_S_LC     = 8'h73;
   localparam logic [7:0] ASCII_D_LC     = 8'h64;
   localparam logic [7:0] ASCII_A_LC     = 8'h61;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ESC  = 2'd1,
      ST_CSI  = 2'd2
   } parse_state_t;

   // Right/left and up/down differ only in bit 0, so the opposite heading is b ^ 1.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return a == (b ^ 2'b01);
   endfunction

   // Returns {hit, direction} for the final byte of an arrow-key sequence.
   function automatic logic [2:0] decode_arrow(input logic [7:0] b);
      case (b)
         ASCII_A: return {1'b1, DIR_UP};
         ASCII_B: return {1'b1, DIR_DOWN};
         ASCII_C: return {1'b1, DIR_RIGHT};
         ASCII_D: return {1'b1, DIR_LEFT};
         default: return {1'b0, DIR_RIGHT};
      endcase
   endfunction

   // Returns {hit, direction} for a single-byte WASD key.
   function automatic logic [2:0] decode_wasd(input logic [7:0] b);
      case (b)
         ASCII_W_LC: return {1'b1, DIR_UP};
         ASCII_S_LC: return {1'b1, DIR_DOWN};
         ASCII_D_LC: return {1'b1, DIR_RIGHT};
         ASCII_A_LC: return {1'b1, DIR_LEFT};
         default:    return {1'b0, DIR_RIGHT};
      endcase
   endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// rtl/snake_turn_fifo.sv - synchronous FIFO of 2-bit turn directions
// Ports: px_clk/rstn clock and sync active-low reset; i_wr_en/i_wr_data push;
//        i_rd_en pop; o_rd_data head entry (combinational); o_level entry count;
//        o_full/o_empty status. A push while full is taken only alongside a pop.
module snake_turn_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     px_clk,
   input  logic                     rstn,
   input  logic                     i_wr_en,
   input  logic [1:0]               i_wr_data,
   input  logic                     i_rd_en,
   output logic [1:0]               o_rd_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          w_do_rd;
   logic          w_do_wr;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_level   = r_level;
   assign o_rd_data = r_mem[r_rptr];

   assign w_do_rd = i_rd_en && !o_empty;
   assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

   always_ff @(posedge px_clk) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (w_do_wr) begin
            r_mem[r_wptr] <= i_wr_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_do_rd) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/snake_cmd_decoder.sv
// rtl/snake_cmd_decoder.sv - UART arrow-key parser, turn filter and per-frame turn release
// Ports: px_clk/rstn clock and sync active-low reset; i_rx_valid/i_rx_data UART byte strobe;
//        i_frame_tick one pulse per frame; o_turn_valid/o_turn_dir released turn;
//        o_fifo_level queued turns; o_overflow sticky drop flag; o_last_byte last UART byte.
// Build option: SNAKE_CMD_WASD_EN adds single-byte w/s/d/a keys decoded in IDLE.
module snake_cmd_decoder
   import snake_pkg::*;
#(
   parameter int         DEPTH       = 4,
   parameter int         TIMEOUT_CYC = 65535,
   parameter logic [1:0] RESET_DIR   = 2'b00
) (
   input  logic                     px_clk,
   input  logic                     rstn,
   input  logic                     i_rx_valid,
   input  logic [7:0]               i_rx_data,
   input  logic                     i_frame_tick,
   output logic                     o_turn_valid,
   output logic [1:0]               o_turn_dir,
   output logic [$clog2(DEPTH):0]   o_fifo_level,
   output logic                     o_overflow,
   output logic [7:0]               o_last_byte
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   parse_state_t  r_state;
   parse_state_t  w_state_nxt;
   logic [TW-1:0] r_tcnt;
   logic          r_cmd_pend;
   logic [1:0]    r_cmd;
   logic [1:0]    r_ref_dir;
   logic          r_overflow;
   logic [7:0]    r_last_byte;
   logic          r_turn_valid;
   logic [1:0]    r_turn_dir;

   logic          w_dec_hit;
   logic [1:0]    w_dec_cmd;
   logic          w_accept;
   logic          w_pop;
   logic          w_can_push;
   logic          w_full;
   logic          w_empty;
   logic [1:0]    w_head;

   always_comb begin
      w_state_nxt = r_state;
      w_dec_hit   = 1'b0;
      w_dec_cmd   = DIR_RIGHT;
      if (i_rx_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (i_rx_data == ASCII_ESC) begin
                  w_state_nxt = ST_ESC;
               end
`ifdef SNAKE_CMD_WASD_EN
               {w_dec_hit, w_dec_cmd} = decode_wasd(i_rx_data);
`endif
            end
            ST_ESC: begin
               if (i_rx_data == ASCII_LBRACKET) w_state_nxt = ST_CSI;
               else if (i_rx_data == ASCII_ESC) w_state_nxt = ST_ESC;
               else                             w_state_nxt = ST_IDLE;
            end
            ST_CSI: begin
               {w_dec_hit, w_dec_cmd} = decode_arrow(i_rx_data);
               w_state_nxt = (i_rx_data == ASCII_ESC) ? ST_ESC : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end else if (r_state != ST_IDLE && r_tcnt == TW'(TIMEOUT_CYC)) begin
         // Stalled sequence: abandon it so a later lone 'A'..'D' is not misread.
         w_state_nxt = ST_IDLE;
      end
   end

   // The decoded command is registered; filtering and the push happen one cycle later.
   assign w_accept   = r_cmd_pend && (r_cmd != r_ref_dir) && !is_reverse(r_cmd, r_ref_dir);
   assign w_pop      = i_frame_tick && !w_empty;
   assign w_can_push = !w_full || w_pop;

   always_ff @(posedge px_clk) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_tcnt       <= '0;
         r_cmd_pend   <= 1'b0;
         r_cmd        <= RESET_DIR;
         r_ref_dir    <= RESET_DIR;
         r_overflow   <= 1'b0;
         r_last_byte  <= 8'h00;
         r_turn_valid <= 1'b0;
         r_turn_dir   <= RESET_DIR;
      end else begin
         r_state <= w_state_nxt;
         if (i_rx_valid || r_state == ST_IDLE) begin
            r_tcnt <= '0;
         end else if (r_tcnt != TW'(TIMEOUT_CYC)) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         if (i_rx_valid) begin
            r_last_byte <= i_rx_data;
         end
         r_cmd_pend <= w_dec_hit;
         r_cmd      <= w_dec_cmd;
         // A dropped turn leaves ref_dir alone so the next key is judged against the real heading.
         if (w_accept) begin
            if (w_can_push) r_ref_dir  <= r_cmd;
            else            r_overflow <= 1'b1;
         end
         r_turn_valid <= w_pop;
         if (w_pop) begin
            r_turn_dir <= w_head;
         end
      end
   end

   snake_turn_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .px_clk    (px_clk),
      .rstn      (rstn),
      .i_wr_en   (w_accept && w_can_push),
      .i_wr_data (r_cmd),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_level   (o_fifo_level),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign o_turn_valid = r_turn_valid;
   assign o_turn_dir   = r_turn_dir;
   assign o_overflow   = r_overflow;
   assign o_last_byte  = r_last_byte;

endmodule

// File: tb/tb_snake_cmd_decoder.sv
// tb/tb_snake_cmd_decoder.sv - self-checking bench for snake_cmd_decoder
module tb_snake_cmd_decoder;

   localparam int         DEPTH = 4;
   localparam int         TMO   = 20;
   localparam logic [1:0] RDIR  = 2'b00;

   logic                   px_clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   rx_valid = 1'b0;
   logic [7:0]             rx_data = 8'h00;
   logic                   frame_tick = 1'b0;
   logic                   turn_valid;
   logic [1:0]             turn_dir;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   overflow;
   logic [7:0]             last_byte;

   int n_checks = 0;
   int n_errors = 0;

   always #5 px_clk = ~px_clk;

   snake_cmd_decoder #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO),
      .RESET_DIR   (RDIR)
   ) dut (
      .px_clk       (px_clk),
      .rstn         (rstn),
      .i_rx_valid   (rx_valid),
      .i_rx_data    (rx_data),
      .i_frame_tick (frame_tick),
      .o_turn_valid (turn_valid),
      .o_turn_dir   (turn_dir),
      .o_fifo_level (fifo_level),
      .o_overflow   (overflow),
      .o_last_byte  (last_byte)
   );

   // Reference model: byte history of the open escape sequence, a queue of turns.
   int         q[$];
   logic [7:0] seq[$];
   int         gap, pend, m_ref, m_tv, m_td, m_lb, m_ovf;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int arrow_dir(input logic [7:0] b);
      case (b)
         8'h41:   return 2;
         8'h42:   return 3;
         8'h43:   return 0;
         8'h44:   return 1;
         default: return -1;
      endcase
   endfunction

   function automatic int wasd_dir(input logic [7:0] b);
      case (b)
         8'h77:   return 2;
         8'h73:   return 3;
         8'h64:   return 0;
         8'h61:   return 1;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      seq.delete();
      gap = 0; pend = -1; m_ref = int'(RDIR); m_tv = 0; m_td = int'(RDIR); m_lb = 0; m_ovf = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (gap > TMO) seq.delete();
      gap = 0;
      if (b == 8'h1B) begin
         seq.delete();
         seq.push_back(b);
      end else if (seq.size() == 1 && b == 8'h5B) begin
         seq.push_back(b);
      end else begin
         if (seq.size() == 2) pend = arrow_dir(b);
`ifdef SNAKE_CMD_WASD_EN
         else if (seq.size() == 0) pend = wasd_dir(b);
`endif
         seq.delete();
      end
   endtask

   // One clock edge of the model: pop for frame_tick, push last cycle's decode, then parse.
   task automatic model_step(input logic v, input logic [7:0] d, input logic t);
      int p;
      p = pend;
      pend = -1;
      m_tv = 0;
      if (t && q.size() > 0) begin
         m_tv = 1;
         m_td = q.pop_front();
      end
      if (p >= 0 && p != m_ref && p != (m_ref ^ 1)) begin
         if (q.size() < DEPTH) begin
            q.push_back(p);
            m_ref = p;
         end else begin
            m_ovf = 1;
         end
      end
      if (v) begin
         m_lb = int'(d);
         model_byte(d);
      end else begin
         gap++;
      end
   endtask

   task automatic compare_all();
      check_eq("turn_valid", int'(turn_valid), m_tv);
      check_eq("turn_dir", int'(turn_dir), m_td);
      check_eq("fifo_level", int'(fifo_level), q.size());
      check_eq("overflow", int'(overflow), m_ovf);
      check_eq("last_byte", int'(last_byte), m_lb);
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic t);
      rx_valid = v; rx_data = d; frame_tick = t;
      @(posedge px_clk);
      model_step(v, d, t);
      @(negedge px_clk);
      rx_valid = 1'b0; frame_tick = 1'b0;
      compare_all();
   endtask

   task automatic do_reset();
      rstn = 1'b0; rx_valid = 1'b0; frame_tick = 1'b0;
      @(posedge px_clk);
      model_reset();
      @(negedge px_clk);
      compare_all();
      rstn = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input int idle);
      cycle(1'b1, b, 1'b0);
      repeat (idle) cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic tick();
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   task automatic arrow(input logic [7:0] c);
      send(8'h1B, 0); send(8'h5B, 0); send(c, 2);
   endtask

   initial begin
      logic [7:0] pool[10];
      pool = '{8'h1B, 8'h5B, 8'h41, 8'h42, 8'h43, 8'h44, 8'h77, 8'h73, 8'h64, 8'h61};

      do_reset();
      check_eq("rst_level", int'(fifo_level), 0);
      check_eq("rst_dir", int'(turn_dir), 0);

      // Slow arrow-up, then release on a frame tick.
      send(8'h1B, 9); send(8'h5B, 9); send(8'h41, 9);
      check_eq("t1_level", int'(fifo_level), 1);
      tick();
      check_eq("t1_pulse", int'(turn_valid), 1);
      check_eq("t1_dir", int'(turn_dir), 2);
      cycle(1'b0, 8'h00, 1'b0);
      check_eq("t1_pulse_end", int'(turn_valid), 0);
      check_eq("t1_dir_hold", int'(turn_dir), 2);

      // Reversal and null turns from reset heading (right).
      do_reset();
      arrow(8'h44);
      check_eq("t2_reverse", int'(fifo_level), 0);
      arrow(8'h43);
      check_eq("t2_null", int'(fifo_level), 0);

      // Fill the FIFO, overflow on the fifth, drain in order.
      arrow(8'h41); arrow(8'h44); arrow(8'h42); arrow(8'h43);
      check_eq("t3_full", int'(fifo_level), 4);
      check_eq("t3_no_ovf", int'(overflow), 0);
      arrow(8'h42);
      check_eq("t3_level", int'(fifo_level), 4);
      check_eq("t3_ovf", int'(overflow), 1);
      tick(); check_eq("t3_pop0", int'(turn_dir), 2);
      tick(); check_eq("t3_pop1", int'(turn_dir), 1);
      tick(); check_eq("t3_pop2", int'(turn_dir), 3);
      tick(); check_eq("t3_pop3", int'(turn_dir), 0);
      tick(); check_eq("t3_empty_tick", int'(turn_valid), 0);

      // Timeout between ESC and '[' kills the sequence; repeated ESC restarts it.
      send(8'h1B, TMO + 1); send(8'h5B, 0); send(8'h41, 2);
      check_eq("t4_timeout", int'(fifo_level), 0);
      send(8'h1B, 0); send(8'h1B, 0); send(8'h5B, 0); send(8'h42, 2);
      check_eq("t4_restart", int'(fifo_level), 1);
      tick(); check_eq("t4_dir", int'(turn_dir), 3);

      // Reset mid-sequence with turns queued.
      arrow(8'h44); arrow(8'h41);
      check_eq("t5_queued", int'(fifo_level), 2);
      send(8'h1B, 0); send(8'h5B, 0);
      do_reset();
      check_eq("t5_level", int'(fifo_level), 0);
      send(8'h41, 2);
      check_eq("t5_lone_a", int'(fifo_level), 0);

      // Single 'w' key.
      send(8'h77, 2);
      check_eq("t6_last_byte", int'(last_byte), 8'h77);
      tick();
`ifdef SNAKE_CMD_WASD_EN
      check_eq("t6_pulse", int'(turn_valid), 1);
      check_eq("t6_dir", int'(turn_dir), 2);
`else
      check_eq("t6_no_pulse", int'(turn_valid), 0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         int r;
         logic v, t;
         logic [7:0] b;
         r = int'($urandom_range(0, 999));
         if (r < 3) begin
            do_reset();
         end else if (r < 25) begin
            repeat ($urandom_range(TMO - 1, TMO + 2)) cycle(1'b0, 8'h00, ($urandom_range(0, 19) == 0));
         end else begin
            v = ($urandom_range(0, 9) < 4);
            t = ($urandom_range(0, 19) == 0);
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            cycle(v, b, t);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
